// File: rtl/xyz_vector_sequencer.sv
// Clocked, self-checking stimulus sequencer for a 3-input/1-output circuit under test.
// Optional macro XYZ_SEQ_LOOP_EN: run passes continuously with a one-cycle done pulse per pass.
module xyz_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [7:0]  EXP_TABLE   = 8'b1110_1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       m,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] err_count_q, err_count_d;
  logic [7:0] fail_vec_q, fail_vec_d;
  logic       sample_edge;
  logic       mismatch;
`ifdef XYZ_SEQ_LOOP_EN
  logic       done_q, done_d;
`endif

  assign sample_edge = (hold_cnt_q == HOLD_LAST);
  assign mismatch    = (m != EXP_TABLE[vec_q]);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    hold_cnt_d  = hold_cnt_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
`ifdef XYZ_SEQ_LOOP_EN
    done_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          vec_d       = '0;
          hold_cnt_d  = '0;
          err_count_d = '0;
          fail_vec_d  = '0;
        end
      end
      ST_RUN: begin
        // abort outranks the sample edge, so the vector being sampled is never compared
        if (abort) begin
          state_d    = ST_IDLE;
          vec_d      = '0;
          hold_cnt_d = '0;
        end else if (sample_edge) begin
          if (mismatch) begin
`ifdef XYZ_SEQ_LOOP_EN
            if (err_count_q != 4'd15) begin
              err_count_d = err_count_q + 4'd1;
            end
`else
            err_count_d = err_count_q + 4'd1;
`endif
            fail_vec_d[vec_q] = 1'b1;
          end
          hold_cnt_d = '0;
          if (vec_q == 3'd7) begin
`ifdef XYZ_SEQ_LOOP_EN
            vec_d  = '0;
            done_d = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      hold_cnt_q  <= '0;
      err_count_q <= '0;
      fail_vec_q  <= '0;
`ifdef XYZ_SEQ_LOOP_EN
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      hold_cnt_q  <= hold_cnt_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
`ifdef XYZ_SEQ_LOOP_EN
      done_q      <= done_d;
`endif
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign x         = busy & vec_q[2];
  assign y         = busy & vec_q[1];
  assign z         = busy & vec_q[0];
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

`ifdef XYZ_SEQ_LOOP_EN
  assign done = done_q;
  assign pass = done_q & (err_count_q == 4'd0);
`else
  assign done = (state_q == ST_DONE);
  assign pass = done & (err_count_q == 4'd0);
`endif

endmodule

// File: tb/tb_xyz_vector_sequencer.sv
// Scoreboard bench for xyz_vector_sequencer: a majority-gate CUT with injectable per-vector faults.
module tb_xyz_vector_sequencer;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       x, y, z, m;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;
  logic [7:0] fault_mask;
  logic [2:0] cut_in;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] err;
    logic [7:0] fail;
    logic       pass;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] seq[$];
  logic       busy_prev, done_prev;

  xyz_vector_sequencer #(.HOLD_CYCLES(H), .EXP_TABLE(8'hE8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x(x), .y(y), .z(z), .m(m),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // Circuit under test: majority gate, with selected vectors inverted
  assign cut_in = {x, y, z};
  assign m = ((x & y) | (y & z) | (x & z)) ^ fault_mask[cut_in];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t expect_for(input logic [7:0] mask, input int prior_err);
    exp_t e;
    int   total;
    total  = prior_err + $countones(mask);
    if (total > 15) total = 15;
    e.err  = 4'(total);
    e.fail = mask;
    e.pass = (total == 0);
    return e;
  endfunction

  // Monitor: at every rising done, compare the reported result and the vector sequence seen since busy rose
  always @(negedge clk) begin
    if (!rst_n) begin
      seq.delete();
      busy_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) seq.delete();
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          int   bad;
          e = exp_q.pop_front();
          check("err_count", 32'(err_count), 32'(e.err));
          check("fail_vec", 32'(fail_vec), 32'(e.fail));
          check("pass", 32'(pass), 32'(e.pass));
          check("seq_len", 32'(seq.size()), 32'(8 * H));
          bad = -1;
          for (int i = 0; i < seq.size(); i++)
            if (bad < 0 && seq[i] !== 3'(i / H)) bad = i;
          check("seq_first_bad_idx", 32'(bad), 32'hFFFF_FFFF);
        end
        seq.delete();
      end
      if (busy) seq.push_back({x, y, z});
      busy_prev = busy;
      done_prev = done;
    end
  end

  // One full single pass; optional spurious start mid-run, optional abort alongside start
  task automatic run(input logic [7:0] mask, input bit spurious, input bit with_abort);
    int cyc, k;
    fault_mask = mask;
    exp_q.push_back(expect_for(mask, 0));
    k = $urandom_range(2, 8 * H - 4);
    start = 1'b1;
    abort = with_abort;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      start = spurious && (cyc == k);
    end while (!done && cyc < 8 * H + 8);
    start = 1'b0;
    // negedges from the start drive to the first sample showing done
    check("done_latency", 32'(cyc), 32'(8 * H + 1));
    if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    check("hold_in_done", {27'd0, done, err_count}, {27'd0, 1'b1, 4'($countones(mask))});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fault_mask = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {14'd0, x, y, z, busy, done, pass, err_count, fail_vec}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {26'd0, x, y, z, busy, done, pass}, 32'd0);

`ifdef XYZ_SEQ_LOOP_EN
    begin
      int cyc;
      fault_mask = 8'hE8;
      for (int p = 0; p < 4; p++) exp_q.push_back(expect_for(8'hE8, 4 * p));
      start = 1'b1;
      for (int p = 0; p < 4; p++) begin
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
          start = 1'b0;
        end while (!done && cyc < 8 * H + 8);
        check("loop_period", 32'(cyc), (p == 0) ? 32'(8 * H + 1) : 32'(8 * H));
        check("loop_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("loop_abort", {28'd0, busy, x, y, z}, 32'd0);
    end
`else
    run(8'h00, 1'b0, 1'b0);
    run(8'hE8, 1'b1, 1'b0);
    run(8'h20, 1'b0, 1'b0);
    run(8'h00, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++) run(8'($urandom), 1'b1, 1'b0);

    // Abort on the sample edge of vector 2 while vectors 1 and 2 are faulty
    fault_mask = 8'h06;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * H - 1) @(negedge clk);
    check("pre_abort", {24'd0, x, y, z, err_count}, {24'd0, 3'b010, 4'd1});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("post_abort_ctl", {27'd0, busy, done, x, y, z}, 32'd0);
    check("post_abort_err", {20'd0, err_count, fail_vec}, {20'd0, 4'd1, 8'h02});
    repeat (3) @(negedge clk);
    check("stays_idle", {30'd0, busy, done}, 32'd0);

    run(8'h81, 1'b0, 1'b1);

    // Asynchronous reset while vector 3 is driven
    fault_mask = 8'h08;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * H + 1) @(negedge clk);
    check("vec3_driven", {29'd0, x, y, z}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {14'd0, x, y, z, busy, done, pass, err_count, fail_vec}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset", {27'd0, x, y, z, busy, done}, 32'd0);
    run(8'h00, 1'b0, 1'b0);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
